// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_add_bit_cell.sv
// One-bit full adder: the only arithmetic in the serial datapath.
module add_bit_cell (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: captures operands on start, adds LSB first one bit per
// cycle, then presents a registered sum/carry with a one-cycle done pulse.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             sum_bit;
    logic             carry_next;
    logic [WIDTH:0]   res_cat;
    logic [WIDTH-1:0] res_next;

    add_bit_cell u_cell (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c_in  (carry),
        .s     (sum_bit),
        .c_out (carry_next)
    );

    // New bit enters at the MSB so the first (LSB) result ends up at bit 0;
    // the concatenation keeps the slice legal when WIDTH is 1.
    assign res_cat  = {sum_bit, res_sr};
    assign res_next = res_cat[WIDTH:1];

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            c_out  <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= c_in;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    carry  <= carry_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_next;
                        c_out <= carry_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized self-checking bench for serial_adder_ctrl at WIDTH=4 and WIDTH=1,
// compared against plain-arithmetic expectations of A+B+c_in.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4;
    logic       busy4, done4;
    logic [3:0] sum4;
    logic       cout4;

    logic       start1;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       busy1, done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] last_sum4;
    logic       last_c4;
    logic       last_sum1;
    logic       last_c1;

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .c_in  (cin4),
        .busy  (busy4),
        .done  (done4),
        .sum   (sum4),
        .c_out (cout4)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .c_in  (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .c_out (cout1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start4 = 1'b1;
        a4     = 4'hF;
        b4     = 4'hF;
        cin4   = 1'b1;
        start1 = 1'b1;
        a1     = 1'b1;
        b1     = 1'b1;
        cin1   = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({busy4, done4, sum4, cout4} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_w4: busy=%b done=%b sum=%h c_out=%b, required all zero",
                     busy4, done4, sum4, cout4);
        end
        n_checks++;
        if ({busy1, done1, sum1, cout1} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_w1: busy=%b done=%b sum=%h c_out=%b, required all zero",
                     busy1, done1, sum1, cout1);
        end
        start4 = 1'b0;
        start1 = 1'b0;
        rst    = 1'b0;
        tick();
        last_sum4 = 4'h0;
        last_c4   = 1'b0;
        last_sum1 = 1'b0;
        last_c1   = 1'b0;
    endtask

    // One complete WIDTH=4 operation from an idle start; optionally jitters
    // start and operands during RUN, which must have no effect.
    task automatic add4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        input logic noisy);
        logic [4:0] total;
        total  = 5'(a) + 5'(b) + 5'(cin);
        a4     = a;
        b4     = b;
        cin4   = cin;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            n_checks++;
            if (busy4 !== 1'b1 || done4 !== 1'b0 || sum4 !== last_sum4 || cout4 !== last_c4) begin
                n_fail++;
                $display("FAIL add4_run cycle %0d: busy=%b done=%b sum=%h c_out=%b, required busy=1 done=0 sum=%h c_out=%b",
                         i, busy4, done4, sum4, cout4, last_sum4, last_c4);
            end
            if (noisy) begin
                start4 = 1'($urandom);
                a4     = 4'($urandom);
                b4     = 4'($urandom);
                cin4   = 1'($urandom);
            end
            tick();
        end
        start4 = 1'b0;
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b1 || {cout4, sum4} !== total) begin
            n_fail++;
            $display("FAIL add4_done %h+%h+%b: busy=%b done=%b c_out=%b sum=%h, required busy=0 done=1 c_out=%b sum=%h",
                     a, b, cin, busy4, done4, cout4, sum4, total[4], total[3:0]);
        end
        last_sum4 = total[3:0];
        last_c4   = total[4];
        tick();
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== last_sum4 || cout4 !== last_c4) begin
            n_fail++;
            $display("FAIL add4_idle: busy=%b done=%b sum=%h c_out=%b, required busy=0 done=0 sum=%h c_out=%b",
                     busy4, done4, sum4, cout4, last_sum4, last_c4);
        end
    endtask

    task automatic test_directed();
        add4(4'h5, 4'h3, 1'b0, 1'b0);
        add4(4'hF, 4'h1, 1'b0, 1'b0);
        add4(4'hF, 4'hF, 1'b1, 1'b0);
        add4(4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 24; k++)
            add4(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic test_ignore_start();
        int n_done;
        n_done = 0;
        a4     = 4'h5;
        b4     = 4'h3;
        cin4   = 1'b0;
        start4 = 1'b1;
        tick();
        for (int c = 1; c <= 12; c++) begin
            if (c == 2) begin
                start4 = 1'b1;
                a4     = 4'h0;
                b4     = 4'h0;
            end else begin
                start4 = 1'b0;
            end
            if (done4 === 1'b1) begin
                n_done++;
                n_checks++;
                if (c != 5 || sum4 !== 4'h8 || cout4 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ignore_start_done: cycle=%0d sum=%h c_out=%b, required cycle=5 sum=8 c_out=0",
                             c, sum4, cout4);
                end
            end
            tick();
        end
        n_checks++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL ignore_start_count: %0d done pulses, required 1", n_done);
        end
        last_sum4 = 4'h8;
        last_c4   = 1'b0;
    endtask

    task automatic test_reset_in_run();
        a4     = 4'h9;
        b4     = 4'h9;
        cin4   = 1'b1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== 4'h0 || cout4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_run: busy=%b done=%b sum=%h c_out=%b, required all zero",
                     busy4, done4, sum4, cout4);
        end
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (done4 !== 1'b0 || busy4 !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_in_run_quiet cycle %0d: busy=%b done=%b, required busy=0 done=0",
                         c, busy4, done4);
            end
        end
        last_sum4 = 4'h0;
        last_c4   = 1'b0;
        last_sum1 = 1'b0;
        last_c1   = 1'b0;
    endtask

    // start held high: each DONE cycle accepts the next operation, so
    // operands are switched exactly during the DONE cycle.
    task automatic test_back_to_back();
        logic [3:0] op_a[8];
        logic [3:0] op_b[8];
        logic       op_c[8];
        logic [4:0] total;
        op_a[0] = 4'h1; op_b[0] = 4'h1; op_c[0] = 1'b0;
        op_a[1] = 4'h2; op_b[1] = 4'h2; op_c[1] = 1'b0;
        for (int k = 2; k < 8; k++) begin
            op_a[k] = 4'($urandom);
            op_b[k] = 4'($urandom);
            op_c[k] = 1'($urandom);
        end
        a4     = op_a[0];
        b4     = op_b[0];
        cin4   = op_c[0];
        start4 = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            total = 5'(op_a[k]) + 5'(op_b[k]) + 5'(op_c[k]);
            for (int i = 1; i <= 4; i++) begin
                n_checks++;
                if (busy4 !== 1'b1 || done4 !== 1'b0 || sum4 !== last_sum4 || cout4 !== last_c4) begin
                    n_fail++;
                    $display("FAIL b2b_run op %0d cycle %0d: busy=%b done=%b sum=%h c_out=%b, required busy=1 done=0 sum=%h c_out=%b",
                             k, i, busy4, done4, sum4, cout4, last_sum4, last_c4);
                end
                a4   = 4'($urandom);
                b4   = 4'($urandom);
                cin4 = 1'($urandom);
                tick();
            end
            n_checks++;
            if (busy4 !== 1'b0 || done4 !== 1'b1 || {cout4, sum4} !== total) begin
                n_fail++;
                $display("FAIL b2b_done op %0d: busy=%b done=%b c_out=%b sum=%h, required busy=0 done=1 c_out=%b sum=%h",
                         k, busy4, done4, cout4, sum4, total[4], total[3:0]);
            end
            last_sum4 = total[3:0];
            last_c4   = total[4];
            if (k < 7) begin
                a4   = op_a[k+1];
                b4   = op_b[k+1];
                cin4 = op_c[k+1];
            end else begin
                start4 = 1'b0;
            end
            tick();
        end
        n_checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0 || sum4 !== last_sum4) begin
            n_fail++;
            $display("FAIL b2b_end: busy=%b done=%b sum=%h, required busy=0 done=0 sum=%h",
                     busy4, done4, sum4, last_sum4);
        end
    endtask

    task automatic test_width1();
        logic [1:0] total;
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                a1   = 1'(k >> 2);
                b1   = 1'(k >> 1);
                cin1 = 1'(k);
            end else begin
                a1   = 1'($urandom);
                b1   = 1'($urandom);
                cin1 = 1'($urandom);
            end
            total  = 2'(a1) + 2'(b1) + 2'(cin1);
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            a1     = 1'($urandom);
            b1     = 1'($urandom);
            n_checks++;
            if (busy1 !== 1'b1 || done1 !== 1'b0 || sum1 !== last_sum1 || cout1 !== last_c1) begin
                n_fail++;
                $display("FAIL w1_run case %0d: busy=%b done=%b sum=%b c_out=%b, required busy=1 done=0 sum=%b c_out=%b",
                         k, busy1, done1, sum1, cout1, last_sum1, last_c1);
            end
            tick();
            n_checks++;
            if (busy1 !== 1'b0 || done1 !== 1'b1 || {cout1, sum1} !== total) begin
                n_fail++;
                $display("FAIL w1_done case %0d: busy=%b done=%b c_out=%b sum=%b, required busy=0 done=1 c_out=%b sum=%b",
                         k, busy1, done1, cout1, sum1, total[1], total[0]);
            end
            last_sum1 = total[0];
            last_c1   = total[1];
            tick();
            n_checks++;
            if (busy1 !== 1'b0 || done1 !== 1'b0) begin
                n_fail++;
                $display("FAIL w1_idle case %0d: busy=%b done=%b, required busy=0 done=0",
                         k, busy1, done1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_in_run();
        test_random();
        test_back_to_back();
        test_width1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, operand/result bit width; legal range 1..16.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to add; sampled every rising edge.
REQ-005 a  input  WIDTH  operand A; sampled only on the accepted start edge.
REQ-006 b  input  WIDTH  operand B; sampled only on the accepted start edge.
REQ-007 c_in  input  1  carry-in; sampled only on the accepted start edge.
REQ-008 busy  output  1  high while the addition is in progress.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  WIDTH  registered result, A+B+c_in modulo 2^WIDTH.
REQ-011 c_out  output  1  registered carry-out of the addition.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE or DONE with start=1 at an edge SHALL capture a, b and c_in, clear the bit counter, and go to RUN.
REQ-014 IDLE with start=0 SHALL stay in IDLE; DONE with start=0 SHALL go to IDLE.
REQ-015 RUN SHALL process exactly one bit per cycle, LSB first, through the one-bit sum/carry cell, for exactly WIDTH cycles.
REQ-016 In RUN, the carry register SHALL feed the cell's carry input and take its carry output each cycle; the bit counter SHALL increment each cycle.
REQ-017 After the final RUN cycle, the FSM SHALL go to DONE and load sum and c_out from the shift result and carry register in the same edge.
REQ-018 Timing: start accepted in cycle 0 -> busy=1 in cycles 1..WIDTH -> done=1 in cycle WIDTH+1 only.
REQ-019 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); busy and done SHALL never both be high.
REQ-020 start SHALL be ignored while in RUN; the operation SHALL complete unchanged, and changes to a, b or c_in SHALL have no effect.
REQ-021 Back-to-back: start=1 during the DONE cycle SHALL be accepted, with busy=1 in the next cycle.
REQ-022 sum and c_out SHALL hold the last completed result from the DONE cycle until the next DONE, including throughout a following RUN.
REQ-023 The bit counter SHALL be $clog2(WIDTH+1) bits wide; WIDTH=1 SHALL give a single RUN cycle.

Reset
REQ-024 rst=1 at an edge SHALL force IDLE, busy=0, done=0, sum=0, c_out=0, and clear the carry register, counter and operand shift registers.
REQ-025 rst SHALL take priority over start in the same cycle.
REQ-026 rst asserted during RUN SHALL abort the operation with no done pulse.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-028 The one-bit sum/carry logic SHALL be a separate combinational sub-module, add_bit_cell, instantiated once.
REQ-029 No combinational path SHALL exist from any input to any output.

Verification
REQ-030 WIDTH=4, a=0x5, b=0x3, c_in=0, start pulse -> busy 4 cycles, done in cycle 5, sum=0x8, c_out=0.
REQ-031 a=0xF, b=0x1, c_in=0 -> sum=0x0, c_out=1; a=0xF, b=0xF, c_in=1 -> sum=0xF, c_out=1.
REQ-032 start re-pulsed in RUN cycle 2 with a=0x0, b=0x0 -> ignored; the first result (0x8, 0) completes and only one done pulse occurs.
REQ-033 rst asserted in RUN cycle 2 -> next cycle busy=0, sum=0, c_out=0, and no done pulse follows.
REQ-034 start held high continuously, with a=0x1, b=0x1 then a=0x2, b=0x2 -> done every 5 cycles; results 0x2 then 0x4; sum stable between done pulses.
REQ-035 WIDTH=1: a=1, b=1, c_in=1 -> busy 1 cycle, done in cycle 2, sum=1, c_out=1.
